alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Shares the single QUAD.nibble ALU between two requesters, port 0 (instruction pipeline) and port 1 (address/auxiliary unit). The block arbitrates round-robin, sequences each operation through the ALU's registered-result / combinational-flag timing, and returns the 16-bit result to the winning requester. It also keeps a separate 5-bit status register (C, Z, N, V, S) per requester. It sits between the requesters and the ALU instance; the ALU's active-low `resetn` is driven as `~reset` at the top level.

## Interface
- No parameters. Widths are fixed: 16-bit data, 4-bit op, op encodings from `constants` (`ALU_OP_*`).
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req0_valid`, `req1_valid` in 1: request presented.
- `req0_ctrl`, `req1_ctrl` in 4: ALU opcode.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` in 16: operands.
- `req0_ready`, `req1_ready` out 1: grant; the handshake completes on `valid & ready`.
- `rsp0_valid`, `rsp1_valid` out 1: one-cycle result pulse. Responses have no backpressure.
- `rsp_y` out 16: result, shared by both ports and qualified by `rspN_valid`.
- `flags0`, `flags1` out 5: per-requester status `{S,V,N,Z,C}`.
- `alu_ctrl` out 4, `alu_a` out 16, `alu_b` out 16: drive the ALU inputs.
- `alu_y` in 16; `alu_c`, `alu_z`, `alu_n`, `alu_v`, `alu_s` in 1: ALU outputs.

## Operation
- FSM states: IDLE, EXEC, WB.
- **IDLE**
  - Arbitrate. If any `reqN_valid`, assert that port's `ready` for exactly one cycle.
  - On the handshake, latch ctrl/a/b/port-id into the op registers and go to EXEC.
- **EXEC**
  - Drive `alu_ctrl/alu_a/alu_b` from the op registers. The ALU registers its result at the end of this cycle.
  - No `ready` is asserted. Go to WB.
- **WB**
  - Hold `alu_ctrl` at the latched op. This is mandatory because the ALU's C/V flags decode the current ctrl against its internally registered operands. `alu_a/alu_b` are don't-care; hold them.
  - Capture `alu_y` into `rsp_y` and update the owning port's flag register. Set `rspN_valid` for the next cycle.
  - Arbitrate exactly as in IDLE. On a handshake go to EXEC; otherwise go to IDLE.
- **Arbitration**
  - A single valid requester wins.
  - When both are valid, the port not granted last time wins.
  - The last-grant pointer resets to 1, so port 0 wins the first contest.
- **Idle drive**: in IDLE, `alu_ctrl = ALU_OP_RSV` and `alu_a = alu_b = 0`.
- **Flag update** (owning port only):
  - Z and N are always taken from the ALU.
  - C and V are taken from the ALU, except for `ALU_OP_MUL`, where the port's previous C and V are kept.
  - S is recomputed as N^V using the stored V. The ALU's S is not used.
  - The other port's flags are never touched.
- **Reset** (any time, including mid-operation): all outputs are 0, state is IDLE, op registers are cleared, and any in-flight operation is dropped with no response.

## Timing
- Handshake in cycle T: EXEC in T+1, WB in T+2, `rspN_valid=1` with `rsp_y` and updated `flagsN` in T+3.
- Handshake-to-response latency: 3 cycles.
- Throughput: at most one operation per 2 cycles. The next handshake can occur in the WB cycle (T+2).
- `rspN_valid` is high for exactly one cycle. `rsp_y` holds its value until the next WB capture.
- `reqN_ready` is combinational from state, valid inputs and the pointer. It is never high in EXEC and never high for both ports at once.
- A requester may drop `valid` before it is granted; no state changes in that case.

## Test plan
- **Port 0 ADD overflow**: ADD 0x7FFF + 0x0001 on port 0 → 3 cycles after the handshake, `rsp0_valid`, `rsp_y` 0x8000, `flags0` = S0 V1 N1 Z0 C0. `flags1` stays 0.
- **Port 1 SUB borrow**: SUB 0x0003 − 0x0005 on port 1 → `rsp_y` 0xFFFE, `flags1` = S1 V0 N1 Z0 C1.
- **MUL keeps C/V**: port 0 ADD 0xFFFF + 0x0001 (`rsp_y` 0x0000, Z1 C1), then MUL 3 × 4 → `rsp_y` 0x000C, C stays 1, V stays 0, Z0 N0 S0.
- **Simultaneous requests**: both ports valid continuously from reset → grants alternate 0,1,0,1 with handshakes spaced 2 cycles apart. Responses arrive in grant order with correct per-port flags.
- **Reset mid-operation**: assert `reset` in the EXEC cycle → no `rsp` pulse; outputs, flags and `alu_ctrl` are 0. After release, port 0 wins first arbitration.
- **Idle**: no requests → `alu_ctrl = ALU_OP_RSV`, `alu_a = alu_b = 0`, both `ready` and both `rspN_valid` low.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for the shared ALU: grants one request at a time,
// walks it through EXEC/WB to meet the ALU's registered-result timing, and keeps per-port flags.
module alu_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [3:0]  req0_ctrl,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic        req1_valid,
    input  logic [3:0]  req1_ctrl,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    output logic [15:0] rsp_y,
    output logic [4:0]  flags0,
    output logic [4:0]  flags1,
    output logic [3:0]  alu_ctrl,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_y,
    input  logic        alu_c,
    input  logic        alu_z,
    input  logic        alu_n,
    input  logic        alu_v,
    input  logic        alu_s
);
    localparam logic [3:0] ALU_OP_MUL = 4'h8;
    localparam logic [3:0] ALU_OP_RSV = 4'hF;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_WB = 2'd2} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_last;
    logic        r_port;
    logic [3:0]  r_ctrl;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [15:0] r_rsp_y;
    logic [4:0]  r_flags0;
    logic [4:0]  r_flags1;
    logic        r_rsp0;
    logic        r_rsp1;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_hs;
    logic        w_unused_s;

    // The ALU's own S is ignored; S is rebuilt from the stored V.
    assign w_unused_s = alu_s;

    // {S,V,N,Z,C}; MUL leaves C and V as they were for that port.
    function automatic logic [4:0] f_flags(input logic [4:0] prev, input logic [3:0] op,
                                           input logic c, input logic z,
                                           input logic n, input logic v);
        logic c_new;
        logic v_new;
        c_new = (op == ALU_OP_MUL) ? prev[0] : c;
        v_new = (op == ALU_OP_MUL) ? prev[3] : v;
        return {n ^ v_new, v_new, n, z, c_new};
    endfunction

    // r_last == 1 means port 1 was granted last, so port 0 wins a tie.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (r_state != S_EXEC) begin
            if (req0_valid && req1_valid) begin
                w_gnt0 = r_last;
                w_gnt1 = ~r_last;
            end else begin
                w_gnt0 = req0_valid;
                w_gnt1 = req1_valid;
            end
        end
    end

    assign w_hs       = w_gnt0 | w_gnt1;
    assign req0_ready = w_gnt0 & ~reset;
    assign req1_ready = w_gnt1 & ~reset;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_hs ? S_EXEC : S_IDLE;
            S_EXEC:  w_next = S_WB;
            S_WB:    w_next = w_hs ? S_EXEC : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_last   <= 1'b1;
            r_port   <= 1'b0;
            r_ctrl   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_rsp_y  <= '0;
            r_flags0 <= '0;
            r_flags1 <= '0;
            r_rsp0   <= 1'b0;
            r_rsp1   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_rsp0  <= 1'b0;
            r_rsp1  <= 1'b0;
            if (w_hs) begin
                r_port <= w_gnt1;
                r_last <= w_gnt1;
                r_ctrl <= w_gnt1 ? req1_ctrl : req0_ctrl;
                r_a    <= w_gnt1 ? req1_a    : req0_a;
                r_b    <= w_gnt1 ? req1_b    : req0_b;
            end
            if (r_state == S_WB) begin
                r_rsp_y <= alu_y;
                r_rsp0  <= ~r_port;
                r_rsp1  <= r_port;
                if (r_port) begin
                    r_flags1 <= f_flags(r_flags1, r_ctrl, alu_c, alu_z, alu_n, alu_v);
                end else begin
                    r_flags0 <= f_flags(r_flags0, r_ctrl, alu_c, alu_z, alu_n, alu_v);
                end
            end
        end
    end

    // ctrl must stay on the latched op through WB: the ALU's C/V decode the live ctrl.
    always_comb begin
        alu_ctrl = ALU_OP_RSV;
        alu_a    = '0;
        alu_b    = '0;
        if (reset) begin
            alu_ctrl = '0;
        end else if (r_state != S_IDLE) begin
            alu_ctrl = r_ctrl;
            alu_a    = r_a;
            alu_b    = r_b;
        end
    end

    assign rsp0_valid = r_rsp0;
    assign rsp1_valid = r_rsp1;
    assign rsp_y      = r_rsp_y;
    assign flags0     = r_flags0;
    assign flags1     = r_flags1;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, scoreboard queue of expected responses,
// and an arithmetic reference model of the per-port flags and round-robin grants.
module tb_alu_arbiter;
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_MUL = 4'h8;
    localparam logic [3:0] OP_RSV = 4'hF;

    logic        clk;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic [3:0]  req0_ctrl, req1_ctrl;
    logic [15:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [15:0] rsp_y;
    logic [4:0]  flags0, flags1;
    logic [3:0]  alu_ctrl;
    logic [15:0] alu_a, alu_b, alu_y;
    logic        alu_c, alu_z, alu_n, alu_v, alu_s;

    alu_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ctrl(req0_ctrl), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ctrl(req1_ctrl), .req1_a(req1_a), .req1_b(req1_b),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_y(rsp_y),
        .flags0(flags0), .flags1(flags1),
        .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b),
        .alu_y(alu_y), .alu_c(alu_c), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v), .alu_s(alu_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: result and operands registered, C/V decoded from the live ctrl.
    logic [15:0] m_a, m_b, m_y;
    logic [31:0] m_prod;
    logic [16:0] m_sum;
    assign m_prod = {16'b0, alu_a} * {16'b0, alu_b};
    assign m_sum  = {1'b0, m_a} + {1'b0, m_b};
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_a <= '0; m_b <= '0; m_y <= '0;
        end else begin
            m_a <= alu_a;
            m_b <= alu_b;
            case (alu_ctrl)
                OP_ADD:  m_y <= alu_a + alu_b;
                OP_SUB:  m_y <= alu_a - alu_b;
                OP_AND:  m_y <= alu_a & alu_b;
                OP_OR:   m_y <= alu_a | alu_b;
                OP_XOR:  m_y <= alu_a ^ alu_b;
                OP_MUL:  m_y <= m_prod[15:0];
                default: m_y <= '0;
            endcase
        end
    end
    always_comb begin
        alu_c = 1'b0;
        alu_v = 1'b0;
        case (alu_ctrl)
            OP_ADD: begin alu_c = m_sum[16]; alu_v = (m_a[15] == m_b[15]) && (m_y[15] != m_a[15]); end
            OP_SUB: begin alu_c = (m_a < m_b); alu_v = (m_a[15] != m_b[15]) && (m_y[15] != m_a[15]); end
            OP_MUL: begin alu_c = 1'b1; alu_v = 1'b1; end
            default: ;
        endcase
    end
    assign alu_y = m_y;
    assign alu_z = (m_y == 16'h0);
    assign alu_n = m_y[15];
    // Deliberately the opposite of N^V, so any use of the ALU's S is visible.
    assign alu_s = ~(alu_n ^ alu_v);

    typedef struct {
        bit          port;
        int          due;
        logic [15:0] y;
        logic [4:0]  f0;
        logic [4:0]  f1;
    } exp_t;

    exp_t        q[$];
    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          hs_cyc = -100;
    bit          last_port = 1'b1;
    logic [4:0]  flags_m[2];
    logic [3:0]  cur_op;
    logic [15:0] cur_a, cur_b;
    bit          dut_hs0, dut_hs1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [15:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h7FFF;
            3: return 16'h8000;
            4: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [3:0] rnd_op();
        case ($urandom_range(0, 5))
            0: return OP_ADD;
            1: return OP_SUB;
            2: return OP_AND;
            3: return OP_OR;
            4: return OP_XOR;
            default: return OP_MUL;
        endcase
    endfunction

    function automatic int sval(input logic [15:0] x);
        return x[15] ? int'(x) - 65536 : int'(x);
    endfunction

    // Reference: result from plain integer arithmetic, overflow as out-of-range signed result.
    task automatic push_exp(input bit p, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int ss;
        longint prod;
        logic [15:0] y;
        bit c, v, z, n;
        c = flags_m[p][0];
        v = flags_m[p][3];
        y = '0;
        case (op)
            OP_ADD: begin
                y = 16'(int'(a) + int'(b));
                c = (int'(a) + int'(b)) > 65535;
                ss = sval(a) + sval(b);
                v = (ss > 32767) || (ss < -32768);
            end
            OP_SUB: begin
                y = 16'(int'(a) - int'(b));
                c = a < b;
                ss = sval(a) - sval(b);
                v = (ss > 32767) || (ss < -32768);
            end
            OP_AND: begin y = a & b; c = 0; v = 0; end
            OP_OR:  begin y = a | b; c = 0; v = 0; end
            OP_XOR: begin y = a ^ b; c = 0; v = 0; end
            default: begin
                prod = longint'(a) * longint'(b);
                y = 16'(prod);
            end
        endcase
        z = (y == 16'h0);
        n = y[15];
        flags_m[p] = {n ^ v, v, n, z, c};
        e.port = p;
        e.due  = cyc + 3;
        e.y    = y;
        e.f0   = flags_m[0];
        e.f1   = flags_m[1];
        q.push_back(e);
    endtask

    // One clock: check grant and ALU drive against the model, record the handshake.
    task automatic step();
        bit e0, e1, in_exec, in_wb;
        @(negedge clk);
        in_exec = (cyc == hs_cyc + 1);
        in_wb   = (cyc == hs_cyc + 2);
        e0 = 0;
        e1 = 0;
        if (!in_exec) begin
            if (req0_valid && req1_valid) begin
                e0 = last_port;
                e1 = !last_port;
            end else begin
                e0 = req0_valid;
                e1 = req1_valid;
            end
        end
        chk("ready0", 32'(req0_ready), 32'(e0));
        chk("ready1", 32'(req1_ready), 32'(e1));
        if (in_exec || in_wb) begin
            chk("alu_ctrl_busy", 32'(alu_ctrl), 32'(cur_op));
            if (in_exec) begin
                chk("alu_a_exec", 32'(alu_a), 32'(cur_a));
                chk("alu_b_exec", 32'(alu_b), 32'(cur_b));
            end
        end else begin
            chk("alu_ctrl_idle", 32'(alu_ctrl), 32'(OP_RSV));
            chk("alu_ab_idle", {alu_a, alu_b}, 32'h0);
        end
        dut_hs0 = req0_valid && req0_ready;
        dut_hs1 = req1_valid && req1_ready;
        if (e0 || e1) begin
            cur_op = e1 ? req1_ctrl : req0_ctrl;
            cur_a  = e1 ? req1_a : req0_a;
            cur_b  = e1 ? req1_b : req0_b;
            hs_cyc = cyc;
            last_port = e1;
            push_exp(e1, cur_op, cur_a, cur_b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit p, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        bit got;
        if (!p) begin req0_valid = 1; req0_ctrl = op; req0_a = a; req0_b = b; end
        else    begin req1_valid = 1; req1_ctrl = op; req1_a = a; req1_b = b; end
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            got = p ? dut_hs1 : dut_hs0;
        end
        if (!got) begin
            n_total++;
            $display("FAIL grant_timeout: port %0d not granted within 20 cycles", p);
        end
        req0_valid = 0;
        req1_valid = 0;
    endtask

    task automatic do_reset();
        reset = 1;
        q.delete();
        flags_m[0] = '0;
        flags_m[1] = '0;
        last_port = 1'b1;
        hs_cyc = -100;
        @(negedge clk);
        chk("rst_ready", {req1_ready, req0_ready}, 32'h0);
        chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 32'h0);
        chk("rst_rsp_y", 32'(rsp_y), 32'h0);
        chk("rst_flags0", 32'(flags0), 32'h0);
        chk("rst_flags1", 32'(flags1), 32'h0);
        chk("rst_alu_ctrl", 32'(alu_ctrl), 32'h0);
        chk("rst_alu_ab", {alu_a, alu_b}, 32'h0);
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic rand_req(input int unsigned pct0, input int unsigned pct1);
        req0_valid = ($urandom_range(0, 99) < pct0);
        req1_valid = ($urandom_range(0, 99) < pct1);
        req0_ctrl = rnd_op(); req0_a = rnd_opnd(); req0_b = rnd_opnd();
        req1_ctrl = rnd_op(); req1_a = rnd_opnd(); req1_b = rnd_opnd();
    endtask

    // Monitor: every response pulse pops and checks the oldest expectation.
    always @(negedge clk) begin
        if (q.size() > 0 && cyc > q[0].due) begin
            n_total++;
            $display("FAIL rsp_missing: port %0d response due cycle %0d not seen", q[0].port, q[0].due);
            void'(q.pop_front());
        end
        if (rsp0_valid || rsp1_valid) begin
            if (q.size() == 0) begin
                n_total++;
                $display("FAIL rsp_spurious: rsp1/rsp0 %b%b with nothing outstanding", rsp1_valid, rsp0_valid);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("rsp_port", {rsp1_valid, rsp0_valid}, e.port ? 32'h2 : 32'h1);
                chk("rsp_latency", cyc, e.due);
                chk("rsp_y", 32'(rsp_y), 32'(e.y));
                chk("flags0", 32'(flags0), 32'(e.f0));
                chk("flags1", 32'(flags1), 32'(e.f1));
            end
        end
    end

    initial begin
        reset = 1;
        req0_valid = 0; req1_valid = 0;
        req0_ctrl = '0; req0_a = '0; req0_b = '0;
        req1_ctrl = '0; req1_a = '0; req1_b = '0;
        cur_op = '0; cur_a = '0; cur_b = '0;
        do_reset();
        for (int i = 0; i < 4; i++) step();

        issue(0, OP_ADD, 16'h7FFF, 16'h0001);
        for (int i = 0; i < 4; i++) step();
        issue(1, OP_SUB, 16'h0003, 16'h0005);
        for (int i = 0; i < 4; i++) step();
        issue(0, OP_ADD, 16'hFFFF, 16'h0001);
        issue(0, OP_MUL, 16'h0003, 16'h0004);
        for (int i = 0; i < 4; i++) step();

        // Reset while the op is in EXEC: the response must never appear.
        issue(0, OP_ADD, 16'h1234, 16'h1111);
        do_reset();
        req0_valid = 1;
        req1_valid = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            rand_req(100, 100);
        end
        req0_valid = 0;
        req1_valid = 0;
        for (int i = 0; i < 4; i++) step();

        for (int i = 0; i < 400; i++) begin
            rand_req(50, 50);
            step();
        end
        req0_valid = 0;
        req1_valid = 0;
        for (int i = 0; i < 6; i++) step();
        chk("queue_drained", q.size(), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
